// File: rtl/edsac_delay_mem_if.sv
// edsac_delay_mem_if: request/response bundle between a requester (CPU core or
// initial-orders loader) and the delay-line word store.
interface edsac_delay_mem_if #(
  parameter int ABITS    = 9,
  parameter int TANKBITS = 5
);
  logic [ABITS-1:0]    memaddr;
  logic [15:0]         memwdata;
  logic                memwr;
  logic                memrd;
  logic                memwait;
  logic [15:0]         memrdata;
  logic                memrvalid;
  logic [TANKBITS-1:0] headpos;

  modport master (
    output memaddr, memwdata, memwr, memrd,
    input  memwait, memrdata, memrvalid, headpos
  );

  modport slave (
    input  memaddr, memwdata, memwr, memrd,
    output memwait, memrdata, memrvalid, headpos
  );
endinterface

// File: rtl/edsac_delay_mem.sv
// edsac_delay_mem: 16-bit word store emulating mercury delay-line tanks.
// Every tank shares one free-running head position; an access completes only
// in the cycle its word offset matches the head, memwait holds the requester
// until then.
// Build option: EDSAC_DELAY_LINE_TIMING_EN enables the delay-line alignment
// wait. Without it every active request is aligned and memwait is always 0;
// headpos keeps counting for debug.
module edsac_delay_mem #(
  parameter int ABITS    = 9,
  parameter int TANKBITS = 5
) (
  input logic               clk,
  input logic               rst_n,
  edsac_delay_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ABITS;

  logic [15:0]         mem [DEPTH];

  logic [TANKBITS-1:0] headpos_q, headpos_d;
  logic [15:0]         memrdata_q, memrdata_d;
  logic                memrvalid_q, memrvalid_d;

  logic                aligned;
  logic                req;
  logic                wr_fire;
  logic                rd_fire;

  // Alignment of the requested word with the shared read/write head.
  always_comb begin
`ifdef EDSAC_DELAY_LINE_TIMING_EN
    aligned = (bus.memaddr[TANKBITS-1:0] == headpos_q);
`else
    aligned = 1'b1;
`endif
  end

  // Request decode: a simultaneous write and read is treated as a write only.
  always_comb begin
    req     = bus.memwr | bus.memrd;
    wr_fire = bus.memwr & aligned;
    rd_fire = bus.memrd & ~bus.memwr & aligned;
  end

  // Next-state for the head counter and the registered read port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    headpos_d   = headpos_q + 1'b1;
    memrvalid_d = rd_fire;
    memrdata_d  = memrdata_q;
    if (rd_fire) begin
      memrdata_d = mem[bus.memaddr];
    end
  end

  // Head position and read-data registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    if (!rst_n) begin
      headpos_q   <= '0;
      memrdata_q  <= '0;
      memrvalid_q <= 1'b0;
    end else begin
      headpos_q   <= headpos_d;
      memrdata_q  <= memrdata_d;
      memrvalid_q <= memrvalid_d;
    end
  end

  // Word storage write at the aligned edge; suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so it maps onto RAM; contents stay
    // undefined until written, and reset only blocks the write enable.
    if (rst_n && wr_fire) begin
      mem[bus.memaddr] <= bus.memwdata;
    end
  end

  assign bus.memwait   = req & ~aligned;
  assign bus.memrdata  = memrdata_q;
  assign bus.memrvalid = memrvalid_q;
  assign bus.headpos   = headpos_q;

endmodule

// File: tb/tb_edsac_delay_mem.sv
// tb_edsac_delay_mem: scenario tasks drive the requester side at posedge+1;
// a reference model predicts head position, waits and read completions at each
// clock edge, pushing expected read data into a queue that a negedge monitor
// pops whenever memrvalid is due.
module tb_edsac_delay_mem;

  localparam int ABITS    = 9;
  localparam int TANKBITS = 5;
  localparam int LIMIT    = 100;
`ifdef EDSAC_DELAY_LINE_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edsac_delay_mem_if #(.ABITS(ABITS), .TANKBITS(TANKBITS)) bus ();

  edsac_delay_mem #(.ABITS(ABITS), .TANKBITS(TANKBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  always @(posedge clk) cycle++;

  // ---------------- reference model + scoreboard ----------------
  logic [TANKBITS-1:0] m_head    = '0;
  logic [15:0]         m_mem [2**ABITS];
  bit                  exp_valid = 1'b0;
  logic [15:0]         m_last    = '0;
  logic [15:0]         exp_q [$];

  function automatic bit m_aligned();
    return !TIMING || (bus.memaddr[TANKBITS-1:0] == m_head);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_head    = '0;
      exp_valid = 1'b0;
      m_last    = '0;
      exp_q.delete();
    end else begin
      exp_valid = 1'b0;
      if (bus.memwr && m_aligned()) begin
        m_mem[bus.memaddr] = bus.memwdata;
      end else if (bus.memrd && m_aligned()) begin
        exp_q.push_back(m_mem[bus.memaddr]);
        exp_valid = 1'b1;
      end
      m_head = m_head + 1'b1;
    end
  end

  always @(negedge clk) begin
    logic exp_wait;
    exp_wait = (bus.memwr | bus.memrd) & ~m_aligned();
    n_checks++;
    if (bus.headpos !== m_head) begin
      n_errors++;
      $display("FAIL mon_headpos t=%0t got %0d want %0d", $time, bus.headpos, m_head);
    end
    n_checks++;
    if (bus.memwait !== exp_wait) begin
      n_errors++;
      $display("FAIL mon_memwait t=%0t got %b want %b", $time, bus.memwait, exp_wait);
    end
    n_checks++;
    if (bus.memrvalid !== exp_valid) begin
      n_errors++;
      $display("FAIL mon_memrvalid t=%0t got %b want %b", $time, bus.memrvalid, exp_valid);
    end
    if (exp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL mon_queue t=%0t got empty want entry", $time);
      end else begin
        m_last = exp_q.pop_front();
      end
    end
    n_checks++;
    if (bus.memrdata !== m_last) begin
      n_errors++;
      $display("FAIL mon_memrdata t=%0t got %h want %h", $time, bus.memrdata, m_last);
    end
  end

  // ---------------- driver helpers (called at posedge+1) ----------------
  task automatic access(input bit wr, input bit rd, input logic [ABITS-1:0] addr,
                        input logic [15:0] data, output int waits,
                        output logic [TANKBITS-1:0] done_head);
    bus.memwr    = wr;
    bus.memrd    = rd;
    bus.memaddr  = addr;
    bus.memwdata = data;
    waits = 0;
    #1;
    while (bus.memwait && waits < LIMIT) begin
      waits++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (waits >= LIMIT) begin
      n_errors++;
      $display("FAIL access_timeout addr=%0d got %0d waits want <%0d", addr, waits, LIMIT);
    end
    done_head = bus.headpos;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memwr = 1'b0;
    bus.memrd = 1'b0;
  endtask

  task automatic sync_head(input logic [TANKBITS-1:0] target);
    int n = 0;
    while (bus.headpos !== target && n < LIMIT) begin
      n++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.headpos !== target) begin
      n_errors++;
      $display("FAIL sync_head got %0d want %0d", bus.headpos, target);
    end
  endtask

  task automatic write_word(input logic [ABITS-1:0] addr, input logic [15:0] data);
    int w;
    logic [TANKBITS-1:0] h;
    access(1'b1, 1'b0, addr, data, w, h);
    idle();
  endtask

  task automatic read_check(input logic [ABITS-1:0] addr, input logic [15:0] want,
                            input string name);
    int w;
    logic [TANKBITS-1:0] h;
    access(1'b0, 1'b1, addr, 16'h0000, w, h);
    idle();
    n_checks++;
    if (bus.memrvalid !== 1'b1 || bus.memrdata !== want) begin
      n_errors++;
      $display("FAIL %s got valid=%b data=%h want valid=1 data=%h",
               name, bus.memrvalid, bus.memrdata, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_isolated_write();
    int w;
    logic [TANKBITS-1:0] h;
    sync_head(5'd3);
    access(1'b1, 1'b0, 9'd10, 16'hA00A, w, h);
    idle();
    n_checks++;
    if (w !== (TIMING ? 7 : 0)) begin
      n_errors++;
      $display("FAIL isolated_write_waits got %0d want %0d", w, TIMING ? 7 : 0);
    end
    read_check(9'd10, 16'hA00A, "isolated_write_readback");
  endtask

  task automatic test_streaming();
    logic [15:0] tbl [38];
    int w, total, start;
    logic [TANKBITS-1:0] h;
    for (int i = 0; i < 38; i++) tbl[i] = 16'h0100 + 16'(i * 7);
    tbl[33] = 16'h0040;
    tbl[35] = 16'h000A;
    total = 0;
    sync_head(5'd0);
    start = cycle;
    for (int i = 0; i < 38; i++) begin
      access(1'b1, 1'b0, ABITS'(i), tbl[i], w, h);
      total += w;
    end
    idle();
    n_checks++;
    if (total !== 0 || (cycle - start) !== 38) begin
      n_errors++;
      $display("FAIL streaming_rate got waits=%0d cycles=%0d want waits=0 cycles=38",
               total, cycle - start);
    end
    read_check(9'd33, 16'h0040, "streaming_read_33");
    read_check(9'd35, 16'h000A, "streaming_read_35");
    read_check(9'd31, tbl[31], "streaming_read_31");
    read_check(9'd32, tbl[32], "streaming_read_32");
  endtask

  task automatic test_read_timing();
    int w;
    logic [TANKBITS-1:0] h;
    write_word(9'd40, 16'hBEEF);
    sync_head(5'd2);
    access(1'b0, 1'b1, 9'd40, 16'h0000, w, h);
    idle();
    n_checks++;
    if (h !== (TIMING ? 5'd8 : 5'd2) || w !== (TIMING ? 6 : 0)) begin
      n_errors++;
      $display("FAIL read_align got head=%0d waits=%0d want head=%0d waits=%0d",
               h, w, TIMING ? 8 : 2, TIMING ? 6 : 0);
    end
    n_checks++;
    if (bus.memrvalid !== 1'b1 || bus.memrdata !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL read_data got valid=%b data=%h want valid=1 data=beef",
               bus.memrvalid, bus.memrdata);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.memrvalid !== 1'b0 || bus.memrdata !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL read_pulse_end got valid=%b data=%h want valid=0 data=beef",
               bus.memrvalid, bus.memrdata);
    end
  endtask

  task automatic test_collision();
    int w;
    logic [TANKBITS-1:0] h;
    access(1'b1, 1'b1, 9'd5, 16'h1234, w, h);
    idle();
    n_checks++;
    if (bus.memrvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL collision_no_read got valid=%b want 0", bus.memrvalid);
    end
    read_check(9'd5, 16'h1234, "collision_readback");
  endtask

  task automatic test_reset();
    write_word(9'd7, 16'h0707);
    read_check(9'd5, 16'h1234, "reset_preload");
    #2;
    bus.memwr    = 1'b1;
    bus.memaddr  = 9'd7;
    bus.memwdata = 16'h7777;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.headpos !== 5'd0 || bus.memrvalid !== 1'b0 || bus.memrdata !== 16'h0000
        || bus.memwait !== TIMING) begin
      n_errors++;
      $display("FAIL reset_async got head=%0d valid=%b data=%h wait=%b want 0 0 0000 %b",
               bus.headpos, bus.memrvalid, bus.memrdata, bus.memwait, TIMING);
    end
    repeat (3) @(posedge clk);
    #1;
    idle();
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.headpos !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_release_first got %0d want 0", bus.headpos);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.headpos !== 5'd1) begin
      n_errors++;
      $display("FAIL reset_release_second got %0d want 1", bus.headpos);
    end
    read_check(9'd7, 16'h0707, "reset_no_write");
  endtask

  task automatic test_drop();
`ifdef EDSAC_DELAY_LINE_TIMING_EN
    write_word(9'd20, 16'h1111);
    sync_head(5'd0);
    bus.memwr    = 1'b1;
    bus.memaddr  = 9'd20;
    bus.memwdata = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.memwait !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_wait got %b want 1", bus.memwait);
    end
    idle();
    read_check(9'd20, 16'h1111, "drop_no_write");
`else
    write_word(9'd20, 16'h1111);
    read_check(9'd20, 16'h1111, "nodelay_rw");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.memwr    = 1'b0;
    bus.memrd    = 1'b0;
    bus.memaddr  = '0;
    bus.memwdata = '0;
    rst_n        = 1'b0;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_isolated_write();
    test_streaming();
    test_read_timing();
    test_collision();
    test_reset();
    test_drop();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edsac_delay_mem.md
# edsac_delay_mem

Word store that answers the memory write/read handshake used by the EDSAC initial-orders loader and the CPU core. It emulates the timing of mercury delay-line tanks. Words circulate past a single read/write head. An access completes only in the cycle its word passes the head; until then `memwait` holds the requester.

## Interface

Parameters:
- `ABITS`, default 9: word address width; store depth is 2^ABITS words of 16 bits.
- `TANKBITS`, default 5: log2 of words per tank (circulation period). Must satisfy 1 ≤ TANKBITS ≤ ABITS.

Ports:
- `clk`  input  1  clock; one word time per cycle.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `memaddr`  input  ABITS  word address; requester holds it stable while `memwait` is high.
- `memwdata`  input  16  write data; held stable with `memaddr`.
- `memwr`  input  1  write request level.
- `memrd`  input  1  read request level.
- `memwait`  output  1  request pending, not yet aligned; requester must hold its request.
- `memrdata`  output  16  read data, registered.
- `memrvalid`  output  1  one-cycle pulse; `memrdata` is valid.
- `headpos`  output  TANKBITS  current head position (debug / testbench).

## Operation

- `headpos` is a free-running TANKBITS-bit counter. It increments every cycle and wraps from 2^TANKBITS−1 to 0. All tanks share one head position.
- A request is active when `memwr` or `memrd` is high.
- Alignment: `memaddr[TANKBITS-1:0] == headpos`. The upper address bits select the tank; alignment ignores them.
- `memwait` is combinational: `(memwr | memrd) & ~aligned`. It is low when no request is active.
- Completion happens in the cycle where a request is active and aligned (`memwait` low).
- Write completion: `mem[memaddr] <= memwdata` at that clock edge.
- Read completion: `memrdata <= mem[memaddr]` and `memrvalid <= 1` at that clock edge. Both are visible the following cycle.
- `memrvalid` is 0 in every cycle not immediately following a read completion.
- `memrdata` holds its last value between reads.
- `memwr` and `memrd` together: treated as a write only. No read is performed and `memrvalid` stays 0.
- Read of a word written in the same cycle is impossible by construction (single port). A read completing the cycle after a write to the same address returns the new data.
- Streaming: a requester that advances `memaddr` by 1 on each completion stays aligned, since the head also advances by 1. After the first alignment wait it runs at one word per cycle. This includes stepping across tank boundaries: address 31→32 with TANKBITS=5 has head 31→0, still aligned.
- Storage contents are not reset. They are undefined until written; a simulation-only init to 0 is permitted.

## Timing

- Wait cycles for an isolated request: `(memaddr[TANKBITS-1:0] − headpos) mod 2^TANKBITS`, in the range 0 … 2^TANKBITS−1.
- Read latency: data appears 1 cycle after completion.
- Reset asserted:
  - `headpos`=0, `memrdata`=0, `memrvalid`=0.
  - `memwait` follows its combinational rule.
  - Any pending request is abandoned; no write occurs while `rst_n` is low.
- Reset deasserted: `headpos` is 0 in the first active cycle and 1 in the next.
- A request dropped while `memwait` is high is a protocol violation. Behaviour is defined anyway: no access occurs and no state changes.

## Configuration

- Macro: `EDSAC_DELAY_LINE_TIMING_EN`.
- Defined: delay-line behaviour as specified above.
- Undefined: every active request is treated as aligned. `memwait` is tied to 0 and each access completes in the cycle it is presented. `headpos` still counts, for debug only. Read latency stays 1 cycle and all reset values are unchanged.

## Test plan

- Reset: drive `rst_n`=0 mid-count. Require `headpos`=0, `memrvalid`=0, `memrdata`=0 immediately (asynchronous). Release: `headpos` reads 0 then 1.
- Isolated write: at `headpos`=3, assert `memwr` with `memaddr`=10, `memwdata`=0xA00A. Require `memwait` high for 7 cycles, low on the 8th, with the write committed at that edge. A later read of 10 returns 0xA00A.
- Streaming: sequential writes of addresses 0–37 (initial-orders load; 37 crosses the tank boundary at 31→32), advancing on `~memwait`, starting at `headpos`=0. Require zero wait cycles and completion in 38 consecutive cycles. Read-back of 33 returns 0x0040 and of 35 returns 0x000A.
- Read timing: request read of address 40 (tank 1, offset 8). Require `memwait` to drop when `headpos`=8 and `memrvalid` to pulse exactly one cycle later with stored data. Require `memrvalid` low on all other cycles.
- Collision: `memwr`=`memrd`=1 at address 5, data 0x1234. Require the write to occur and `memrvalid` to stay 0. A subsequent read returns 0x1234.
- Macro off: build without `EDSAC_DELAY_LINE_TIMING_EN`. Require `memwait`=0 always. A read of any address pulses `memrvalid` on the cycle after issue.
